// File: rtl/battle_front_ctrl.sv
// battle_front_ctrl: paces game ticks, broadcasts move/damage strobes, tracks
// each side's front and delivers each side's total attack to the opposing
// frontmost unit.
// Optional feature macro: BATTLE_SPLASH_EN (damage also hits every alive unit
// standing on the target's position).
module battle_front_ctrl #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter logic [8:0]  FIELD_END = 9'd511
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [35:0] enemyPos,
  input  logic [31:0] enemyDmgOut,
  input  logic [7:0]  enemyType,
  input  logic [35:0] playerPos,
  input  logic [31:0] playerDmgOut,
  input  logic [7:0]  playerType,
  output logic        moveSCEN,
  output logic        damageSCEN,
  output logic [8:0]  playerFront,
  output logic [8:0]  enemyFront,
  output logic [31:0] enemyDamageIn,
  output logic [31:0] playerDamageIn
);

  localparam int unsigned NSLOT  = 4;
  localparam int unsigned POS_W  = 9;
  localparam int unsigned DMG_W  = 8;
  localparam int unsigned TYPE_W = 2;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, MOVE, SETTLE, SUM, DAMAGE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;

  logic [NSLOT-1:0]   player_alive, enemy_alive;
  logic               player_any, enemy_any;
  logic [POS_W-1:0]   player_front_c, enemy_front_c;
  logic [IDX_W-1:0]   player_tgt, enemy_tgt;
  logic [SUM_W-1:0]   player_sum, enemy_sum;
  logic [DMG_W-1:0]   player_total, enemy_total;
  logic [NSLOT-1:0]   player_hit, enemy_hit;

  // Alive flags: any nonzero unit type is a living unit.
  always_comb begin
    player_alive = '0;
    enemy_alive  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      player_alive[i] = |playerType[TYPE_W*i +: TYPE_W];
      enemy_alive[i]  = |enemyType[TYPE_W*i +: TYPE_W];
    end
  end

  // Frontmost alive unit per side; strict compare keeps the lowest index on ties.
  always_comb begin
    player_any     = 1'b0;
    player_front_c = FIELD_END;
    player_tgt     = '0;
    enemy_any      = 1'b0;
    enemy_front_c  = '0;
    enemy_tgt      = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (player_alive[i] &&
          (!player_any || playerPos[POS_W*i +: POS_W] < player_front_c)) begin
        player_any     = 1'b1;
        player_front_c = playerPos[POS_W*i +: POS_W];
        player_tgt     = IDX_W'(i);
      end
      if (enemy_alive[i] &&
          (!enemy_any || enemyPos[POS_W*i +: POS_W] > enemy_front_c)) begin
        enemy_any     = 1'b1;
        enemy_front_c = enemyPos[POS_W*i +: POS_W];
        enemy_tgt     = IDX_W'(i);
      end
    end
  end

  // Per-side attack totals over alive units, saturated to one damage byte.
  always_comb begin
    player_sum = '0;
    enemy_sum  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (player_alive[i]) player_sum = player_sum + SUM_W'(playerDmgOut[DMG_W*i +: DMG_W]);
      if (enemy_alive[i])  enemy_sum  = enemy_sum  + SUM_W'(enemyDmgOut[DMG_W*i +: DMG_W]);
    end
    player_total = (player_sum > SUM_W'(255)) ? 8'hFF : player_sum[DMG_W-1:0];
    enemy_total  = (enemy_sum  > SUM_W'(255)) ? 8'hFF : enemy_sum[DMG_W-1:0];
  end

  // Slots that take damage on each side (target, plus co-located units with splash).
  always_comb begin
    player_hit = player_any ? (NSLOT'(1) << player_tgt) : '0;
    enemy_hit  = enemy_any  ? (NSLOT'(1) << enemy_tgt)  : '0;
`ifdef BATTLE_SPLASH_EN
    for (int i = 0; i < NSLOT; i++) begin
      if (player_any && player_alive[i] && playerPos[POS_W*i +: POS_W] == player_front_c)
        player_hit[i] = 1'b1;
      if (enemy_any && enemy_alive[i] && enemyPos[POS_W*i +: POS_W] == enemy_front_c)
        enemy_hit[i] = 1'b1;
    end
`endif
  end

  // State and tick counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and tick counter logic; run only gates counting in IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (run) begin
          if (cnt == CNT_W'(TICK_DIV - 1)) begin
            state_next = MOVE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      MOVE:    state_next = SETTLE;
      SETTLE:  state_next = SUM;
      SUM:     state_next = DAMAGE;
      DAMAGE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs: strobes track the upcoming state, fronts sample in IDLE,
  // damage buses carry totals only during DAMAGE.
  always_ff @(posedge clk) begin
    if (reset) begin
      moveSCEN       <= 1'b0;
      damageSCEN     <= 1'b0;
      playerFront    <= FIELD_END;
      enemyFront     <= '0;
      enemyDamageIn  <= '0;
      playerDamageIn <= '0;
    end else begin
      moveSCEN   <= (state_next == MOVE);
      damageSCEN <= (state_next == DAMAGE);
      if (state == IDLE) begin
        playerFront <= player_front_c;
        enemyFront  <= enemy_front_c;
      end
      for (int i = 0; i < NSLOT; i++) begin
        playerDamageIn[DMG_W*i +: DMG_W] <=
          (state_next == DAMAGE && player_hit[i]) ? enemy_total : '0;
        enemyDamageIn[DMG_W*i +: DMG_W] <=
          (state_next == DAMAGE && enemy_hit[i]) ? player_total : '0;
      end
    end
  end

endmodule

// File: doc/battle_front_ctrl.md
# battle_front_ctrl

Battlefront calculator that drives the combat lanes of the game. It paces the game in ticks and broadcasts the move and damage strobes to four enemy and four player unit slots. It computes each side's frontmost alive position and feeds it to the opposing side as the unit-front target. It also totals each side's attack output and delivers it as damage to the opposing frontmost unit.

## Interface
- TICK_DIV, 1000: idle clock cycles between game ticks (≥2)
- FIELD_END, 9'd511: enemy target position when no player unit is alive
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- run  in  1  tick counter advances only while high
- enemyPos  in  36  4×9-bit enemy positions, slot i at [9i+8:9i]
- enemyDmgOut  in  32  4×8-bit enemy damageOut
- enemyType  in  8  4×2-bit; nonzero = alive
- playerPos  in  36  4×9-bit player positions
- playerDmgOut  in  32  4×8-bit player damageOut
- playerType  in  8  4×2-bit; nonzero = alive
- moveSCEN  out  1  one-cycle move strobe, broadcast to all slots
- damageSCEN  out  1  one-cycle damage strobe, broadcast to all slots
- playerFront  out  9  unitFront for the enemies (minimum alive player position)
- enemyFront  out  9  unitFront for the players (maximum alive enemy position)
- enemyDamageIn  out  32  4×8-bit damage to enemy slots
- playerDamageIn  out  32  4×8-bit damage to player slots

## Operation
- States: IDLE, MOVE, SETTLE, SUM, DAMAGE.
- IDLE
  - While run=1, the tick counter counts 0..TICK_DIV-1.
  - At terminal count, go to MOVE and clear the counter.
  - While run=0, the counter holds.
  - Fronts are re-registered every IDLE cycle and held in all other states.
- MOVE: moveSCEN=1 for one cycle, then SETTLE.
- SETTLE: one wait cycle so that unit damageOut registers update, then SUM.
- SUM
  - Register per-side totals: the sum of alive units' DmgOut, 10-bit, saturated to 255.
  - Register the target slot per side: the frontmost alive unit, with the lowest index winning ties.
- DAMAGE
  - damageSCEN=1.
  - The target player slot receives the enemy total.
  - The target enemy slot receives the player total.
  - All other slots receive 0.
  - Next state is IDLE.
- Front computation
  - playerFront = minimum position over alive players, or FIELD_END if none are alive.
  - enemyFront = maximum position over alive enemies, or 0 if none are alive.
- Damage bus rule: both damage buses are 0 in every state except DAMAGE, because units compare health against damageIn every cycle.
- No target on a side (no alive unit): that side's bus stays all-zero; damageSCEN still pulses.
- A unit that dies between SUM and DAMAGE still receives its damage; no re-selection is done.

## Timing
- Reset values: state IDLE, counter 0, moveSCEN=0, damageSCEN=0, playerFront=FIELD_END, enemyFront=0, both damage buses 0.
- Tick period is TICK_DIV+4 cycles while run is held high.
- moveSCEN rises TICK_DIV cycles after entry to IDLE. damageSCEN rises 3 cycles after moveSCEN.
- Fronts presented during MOVE equal the values registered on the last IDLE cycle. They are stable for the whole MOVE cycle.
- run dropping outside IDLE does not abort the tick; the controller returns to IDLE and holds there.
- reset in any state returns to reset values on the next clock edge. Strobes never extend past that edge.

## Configuration
- BATTLE_SPLASH_EN
  - Defined: damage goes to every alive unit whose position equals the target's position, on both sides, with the same value for each.
  - Undefined: only the single target slot receives damage.

## Test plan
- Front / move pacing
  - Setup: TICK_DIV=4, run=1; playerPos slots 300/250/400/—, all alive except slot 3; no alive enemy.
  - Required: playerFront=250 and enemyFront=0; moveSCEN pulses on cycles 4, 12, 20 after reset release; damage buses stay 0.
- Enemy totals, saturation and tie
  - Setup: enemies alive with DmgOut 0x20/0x20/0x80/0x80; player slots 1 and 2 alive, both at 100.
  - Required: playerDamageIn slot 1 = 0xFF during the damageSCEN cycle only; slot 2 = 0; all slots 0 on neighbouring cycles.
- Dead units excluded
  - Setup: enemy slot 0 has Type=0, DmgOut=0x40; slot 1 alive, DmgOut=0x10, position 90; player alive at 120 with DmgOut 0x30.
  - Required: player target gets 0x10; enemyDamageIn slot 1 = 0x30; enemyFront=90.
- run gating
  - Stimulus: drop run at counter=2 for 10 cycles, then raise it.
  - Required: no strobes while run is low; moveSCEN follows 2 cycles after run returns.
- Reset mid-tick
  - Stimulus: assert reset during SETTLE.
  - Required: damageSCEN never pulses; outputs equal reset values the next cycle; the next moveSCEN comes TICK_DIV cycles after reset release.
- BATTLE_SPLASH_EN defined
  - Setup: player slots 0 and 3 both at 200; enemy total 0x25.
  - Required: both slots receive 0x25. With the macro undefined, only slot 0 receives it.
